sdram_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 15 +
 rtl/rd_owner_fifo.sv | 55 +++++
 rtl/sdram_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM arbiter: FSM state encoding and master identifiers.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

endpackage

// File: rtl/rd_owner_fifo.sv
// Owner FIFO for outstanding reads: remembers which master issued each accepted read
// so returning beats can be steered back in order.
module rd_owner_fifo
    import sdram_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  master_id_t       din,
    output master_id_t       dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of one SDRAM controller slave,
// steering pipelined read beats back to the issuing master.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int ADDR_W   = 25,
    parameter  int DATA_W   = 16,
    parameter  int MAX_PEND = 4,
    localparam int BE_W     = DATA_W / 8,
    localparam int CNT_W    = $clog2(MAX_PEND) + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic [CNT_W-1:0]  pend_count
);

    arb_state_t state;
    arb_state_t state_next;
    master_id_t last;
    master_id_t gid;
    master_id_t head_id;
    logic       req0;
    logic       req1;
    logic       g_read;
    logic       g_write;
    logic       read_blocked;
    logic       accept;
    logic       fifo_empty;
    logic       fifo_full;

    assign req0 = m0_read || m0_write;
    assign req1 = m1_read || m1_write;
    assign gid  = (state == GRANT1) ? MASTER1 : MASTER0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            last  <= MASTER1;
        end else begin
            state <= state_next;
            if (accept) last <= gid;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        g_read         = 1'b0;
        g_write        = 1'b0;
        read_blocked   = 1'b0;
        accept         = 1'b0;

        case (state)
            IDLE: begin
                if (req0 && req1)  state_next = (last == MASTER0) ? GRANT1 : GRANT0;
                else if (req0)     state_next = GRANT0;
                else if (req1)     state_next = GRANT1;
            end
            GRANT0, GRANT1: begin
                s_address    = (gid == MASTER1) ? m1_address    : m0_address;
                s_writedata  = (gid == MASTER1) ? m1_writedata  : m0_writedata;
                s_byteenable = (gid == MASTER1) ? m1_byteenable : m0_byteenable;
                g_read       = (gid == MASTER1) ? m1_read       : m0_read;
                g_write      = (gid == MASTER1) ? m1_write      : m0_write;

                // Read-and-write together is illegal; the read wins.
                read_blocked = g_read && fifo_full;
                s_read       = g_read && !read_blocked;
                s_write      = g_write && !g_read;
                accept       = (s_read || s_write) && !s_waitrequest;

                if (gid == MASTER1) m1_waitrequest = s_waitrequest || read_blocked;
                else                m0_waitrequest = s_waitrequest || read_blocked;

                if (accept) begin
                    if (gid == MASTER1) state_next = req0 ? GRANT0 : IDLE;
                    else                state_next = req1 ? GRANT1 : IDLE;
                end else if (!(g_read || g_write)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    rd_owner_fifo #(
        .DEPTH (MAX_PEND)
    ) u_owner_fifo (
        .clk   (Clk),
        .reset (Reset),
        .push  (accept && s_read),
        .pop   (s_readdatavalid),
        .din   (gid),
        .dout  (head_id),
        .count (pend_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Beats with no recorded owner (e.g. stale ones after reset) go nowhere.
    assign m0_readdatavalid = s_readdatavalid && !fifo_empty && (head_id == MASTER0);
    assign m1_readdatavalid = s_readdatavalid && !fifo_empty && (head_id == MASTER1);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: arbitration order, read steering,
// read blocking, slave stalls and reset recovery.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [2:0]        pend_count;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .pend_count(pend_count)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic apply_reset();
        Reset = 1;
        clear_inputs();
        step();
        step();
        Reset = 0;
    endtask

    // Raises one master's read and waits (bounded) until it is accepted.
    task automatic do_read(input master_id_t id, input logic [ADDR_W-1:0] a);
        int n = 0;
        if (id == MASTER1) begin m1_read = 1; m1_address = a; end
        else               begin m0_read = 1; m0_address = a; end
        #1;
        while (((id == MASTER1) ? m1_waitrequest : m0_waitrequest) !== 1'b0 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (n >= 8) begin
            failures++;
            $display("FAIL do_read_timeout master=%0d got=waitrequest_stuck exp=accept", id);
        end
        step();
        m0_read = 0;
        m1_read = 0;
    endtask

    task automatic test_reset();
        Reset = 1;
        clear_inputs();
        m0_read = 1;
        m0_address = 25'h1234;
        step();
        step();
        checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin failures++;
            $display("FAIL reset_cmd got=%0b%0b exp=00", s_read, s_write); end
        checks++; if (s_address !== '0 || s_writedata !== '0) begin failures++;
            $display("FAIL reset_addr_data got=%h/%h exp=0/0", s_address, s_writedata); end
        checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin failures++;
            $display("FAIL reset_waitreq got=%0b%0b exp=11", m0_waitrequest, m1_waitrequest); end
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || pend_count !== 3'd0) begin failures++;
            $display("FAIL reset_rdv_pend got=%0b%0b/%0d exp=00/0", m0_readdatavalid, m1_readdatavalid, pend_count); end
        Reset = 0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        apply_reset();
        m0_read = 1;
        m0_address = 25'h000010;
        #1;
        checks++; if (s_read !== 1'b0) begin failures++;
            $display("FAIL single_idle_s_read got=%0b exp=0", s_read); end
        step();
        checks++; if (s_read !== 1'b1 || s_address !== 25'h000010) begin failures++;
            $display("FAIL single_cycle1 got=%0b/%h exp=1/000010", s_read, s_address); end
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin failures++;
            $display("FAIL single_waitreq got=%0b%0b exp=01", m0_waitrequest, m1_waitrequest); end
        step();
        m0_read = 0;
        #1;
        checks++; if (pend_count !== 3'd1 || m0_readdatavalid !== 1'b0) begin failures++;
            $display("FAIL single_pending got=%0d/%0b exp=1/0", pend_count, m0_readdatavalid); end
        step();
        s_readdatavalid = 1;
        s_readdata = 16'hBEEF;
        #1;
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 16'hBEEF) begin failures++;
            $display("FAIL single_beat got=%0b/%h exp=1/beef", m0_readdatavalid, m0_readdata); end
        checks++; if (m1_readdatavalid !== 1'b0) begin failures++;
            $display("FAIL single_m1_rdv got=%0b exp=0", m1_readdatavalid); end
        step();
        s_readdatavalid = 0;
        #1;
        checks++; if (pend_count !== 3'd0) begin failures++;
            $display("FAIL single_drain got=%0d exp=0", pend_count); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        apply_reset();
        m0_write = 1; m0_address = 25'h100; m0_writedata = 16'hA000; m0_byteenable = 2'b11;
        m1_write = 1; m1_address = 25'h200; m1_writedata = 16'hB000; m1_byteenable = 2'b01;
        step();
        for (int i = 0; i < 6; i++) begin
            exp_addr = (i % 2 == 0) ? 25'h100 : 25'h200;
            exp_data = (i % 2 == 0) ? 16'hA000 : 16'hB000;
            checks++; if (s_write !== 1'b1 || s_address !== exp_addr || s_writedata !== exp_data) begin failures++;
                $display("FAIL b2b_cmd%0d got=%0b/%h/%h exp=1/%h/%h", i, s_write, s_address, s_writedata, exp_addr, exp_data); end
            checks++; if (m0_waitrequest !== (i % 2 == 1) || m1_waitrequest !== (i % 2 == 0)) begin failures++;
                $display("FAIL b2b_waitreq%0d got=%0b%0b exp=%0b%0b", i, m0_waitrequest, m1_waitrequest, (i % 2 == 1), (i % 2 == 0)); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_read_block();
        apply_reset();
        m1_read = 1;
        m1_address = 25'h300;
        #1;
        // A lone master alternates IDLE and GRANT1, so reads are accepted on odd cycles.
        for (int k = 0; k < 8; k++) begin
            checks++; if (s_read !== (k % 2 == 1)) begin failures++;
                $display("FAIL block_stream%0d got=%0b exp=%0b", k, s_read, (k % 2 == 1)); end
            step();
        end
        checks++; if (pend_count !== 3'd4) begin failures++;
            $display("FAIL block_pend4 got=%0d exp=4", pend_count); end
        step();
        for (int k = 0; k < 2; k++) begin
            checks++; if (s_read !== 1'b0 || m1_waitrequest !== 1'b1 || dut.state !== GRANT1) begin failures++;
                $display("FAIL block_held%0d got=%0b/%0b/%0d exp=0/1/%0d", k, s_read, m1_waitrequest, dut.state, GRANT1); end
            step();
        end
        s_readdatavalid = 1;
        s_readdata = 16'h5555;
        #1;
        checks++; if (m1_readdatavalid !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0) begin failures++;
            $display("FAIL block_pop_cycle got=%0b/%0b/%0b exp=1/1/0", m1_readdatavalid, m1_waitrequest, s_read); end
        step();
        s_readdatavalid = 0;
        #1;
        checks++; if (pend_count !== 3'd3 || s_read !== 1'b1 || m1_waitrequest !== 1'b0) begin failures++;
            $display("FAIL block_release got=%0d/%0b/%0b exp=3/1/0", pend_count, s_read, m1_waitrequest); end
        step();
        m1_read = 0;
        #1;
        checks++; if (pend_count !== 3'd4) begin failures++;
            $display("FAIL block_repush got=%0d exp=4", pend_count); end
        clear_inputs();
    endtask

    task automatic test_interleaved();
        master_id_t        owner [4] = '{MASTER0, MASTER1, MASTER1, MASTER0};
        logic [DATA_W-1:0] beat  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        apply_reset();
        for (int i = 0; i < 4; i++) do_read(owner[i], ADDR_W'(32'h40 + i));
        #1;
        checks++; if (pend_count !== 3'd4) begin failures++;
            $display("FAIL inter_pend got=%0d exp=4", pend_count); end
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1;
            s_readdata = beat[i];
            #1;
            checks++;
            if (m0_readdatavalid !== (owner[i] == MASTER0) || m1_readdatavalid !== (owner[i] == MASTER1) ||
                ((owner[i] == MASTER1) ? m1_readdata : m0_readdata) !== beat[i]) begin
                failures++;
                $display("FAIL inter_beat%0d got=%0b%0b/%h exp=%0b%0b/%h", i, m0_readdatavalid, m1_readdatavalid,
                         (owner[i] == MASTER1) ? m1_readdata : m0_readdata,
                         (owner[i] == MASTER0), (owner[i] == MASTER1), beat[i]);
            end
            step();
            s_readdatavalid = 0;
        end
        #1;
        checks++; if (pend_count !== 3'd0) begin failures++;
            $display("FAIL inter_drain got=%0d exp=0", pend_count); end
    endtask

    task automatic test_slave_stall();
        apply_reset();
        m0_write = 1; m0_address = 25'h400; m0_writedata = 16'h1234; m0_byteenable = 2'b11;
        m1_write = 1; m1_address = 25'h500; m1_writedata = 16'h5678; m1_byteenable = 2'b11;
        s_waitrequest = 1;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++; if (s_write !== 1'b1 || s_address !== 25'h400 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin failures++;
                $display("FAIL stall%0d got=%0b/%h/%0b%0b exp=1/400/11", k, s_write, s_address, m0_waitrequest, m1_waitrequest); end
            step();
        end
        s_waitrequest = 0;
        #1;
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin failures++;
            $display("FAIL stall_accept got=%0b%0b exp=01", m0_waitrequest, m1_waitrequest); end
        step();
        m0_write = 0;
        #1;
        checks++; if (s_address !== 25'h500 || s_writedata !== 16'h5678 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin failures++;
            $display("FAIL stall_handover got=%h/%h/%0b%0b exp=500/5678/10", s_address, s_writedata, m0_waitrequest, m1_waitrequest); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        do_read(MASTER0, 25'h60);
        do_read(MASTER1, 25'h61);
        #1;
        checks++; if (pend_count !== 3'd2) begin failures++;
            $display("FAIL midrst_pend_before got=%0d exp=2", pend_count); end
        m0_read = 1;
        s_waitrequest = 1;
        step();
        Reset = 1;
        step();
        Reset = 0;
        clear_inputs();
        #1;
        checks++; if (pend_count !== 3'd0 || dut.state !== IDLE || s_read !== 1'b0) begin failures++;
            $display("FAIL midrst_state got=%0d/%0d/%0b exp=0/%0d/0", pend_count, dut.state, s_read, IDLE); end
        s_readdatavalid = 1;
        s_readdata = 16'hDEAD;
        #1;
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin failures++;
            $display("FAIL midrst_stale_rdv got=%0b%0b exp=00", m0_readdatavalid, m1_readdatavalid); end
        step();
        s_readdatavalid = 0;
        #1;
        checks++; if (pend_count !== 3'd0) begin failures++;
            $display("FAIL midrst_no_underflow got=%0d exp=0", pend_count); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_read_block();
        test_interleaved();
        test_slave_stall();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
